// File: rtl/issue_stage_pkg.sv
// Shared types for the issue stage: rs entry layout, functional-unit classes
// and the opcode helpers used to steer a packet onto a unit.
package issue_stage_pkg;

    localparam int unsigned ISSUE_WIDTH = 2;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLT,
        ALU_SLTU,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SLL,
        ALU_SRL,
        ALU_SRA,
        ALU_MUL,
        ALU_MULH,
        ALU_MULHSU,
        ALU_MULHU,
        ALU_DIV,
        ALU_REM
    } ALU_FUNC;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  dest_reg_idx;
        ALU_FUNC     alu_func;
        logic        rd_mem;
        logic        wr_mem;
    } ID_DISP_PACKET;

    typedef struct packed {
        logic          busy;
        logic          send_issue;
        logic [5:0]    T;
        logic [5:0]    T1;
        logic [5:0]    T2;
        ID_DISP_PACKET packet;
    } RS_OBJ;

    typedef enum logic [1:0] {
        FU_ALU,
        FU_MULT,
        FU_MEM
    } FU_CLASS;

    function automatic logic is_mult(input ID_DISP_PACKET p);
        return p.alu_func inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU};
    endfunction

    // Memory access wins over the opcode so a load/store never lands on the multiplier.
    function automatic FU_CLASS fu_class_of(input ID_DISP_PACKET p);
        if (p.rd_mem || p.wr_mem) begin
            return FU_MEM;
        end else if (is_mult(p)) begin
            return FU_MULT;
        end
        return FU_ALU;
    endfunction

endpackage

// File: rtl/issue_stage_fu_arbiter.sv
// Per-class priority grant: lane 0 first; the multiplier and memory port each
// accept at most one op per cycle, ALU ops are always granted.
module fu_arbiter
    import issue_stage_pkg::*;
#(
    parameter int unsigned WIDTH = ISSUE_WIDTH
) (
    input  logic    [WIDTH-1:0] is_valid,
    input  FU_CLASS [WIDTH-1:0] fu_class,
    input  logic                mult_free,
    input  logic                mem_ready,
    output logic    [WIDTH-1:0] grant
);

    logic mult_taken;
    logic mem_taken;

    always_comb begin
        grant      = '0;
        mult_taken = 1'b0;
        mem_taken  = 1'b0;
        for (int unsigned w = 0; w < WIDTH; w++) begin
            if (is_valid[w]) begin
                case (fu_class[w])
                    FU_ALU: begin
                        grant[w] = 1'b1;
                    end
                    FU_MULT: begin
                        if (mult_free && !mult_taken) begin
                            grant[w]   = 1'b1;
                            mult_taken = 1'b1;
                        end
                    end
                    FU_MEM: begin
                        if (mem_ready && !mem_taken) begin
                            grant[w]  = 1'b1;
                            mem_taken = 1'b1;
                        end
                    end
                    default: begin
                        grant[w] = 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/issue_stage.sv
// Issue stage between rs and ex: latches rs selections, grants each lane onto a
// functional unit, confirms deletion back to rs and registers granted ops for ex.
module issue_stage
    import issue_stage_pkg::*;
#(
    parameter int unsigned WIDTH    = ISSUE_WIDTH,
    parameter int unsigned MULT_LAT = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                rollback_en,
    input  RS_OBJ   [WIDTH-1:0] issue_packet,
    input  logic                mem_ready,
    output logic    [WIDTH-1:0] delete_confirm,
    output RS_OBJ   [WIDTH-1:0] ex_packet,
    output logic    [WIDTH-1:0] ex_valid,
    output FU_CLASS [WIDTH-1:0] ex_fu,
    output logic                mult_busy
);

    localparam int unsigned CNT_W = (MULT_LAT < 1) ? 1 : $clog2(MULT_LAT + 1);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    if (MULT_LAT < 1) begin : g_bad_mult_lat
        $error("issue_stage: MULT_LAT must be at least 1");
    end

    RS_OBJ   [WIDTH-1:0] is_reg_q,    is_reg_d;
    logic    [WIDTH-1:0] is_valid_q,  is_valid_d;
    RS_OBJ   [WIDTH-1:0] ex_packet_q, ex_packet_d;
    logic    [WIDTH-1:0] ex_valid_q,  ex_valid_d;
    FU_CLASS [WIDTH-1:0] ex_fu_q,     ex_fu_d;
    logic    [CNT_W-1:0] mult_cnt_q,  mult_cnt_d;

    FU_CLASS [WIDTH-1:0] is_fu;
    logic    [WIDTH-1:0] grant;
    logic    [WIDTH-1:0] confirm;
    logic                mult_free;
    logic                mult_take;

    assign mult_free = (mult_cnt_q == '0);

    always_comb begin
        is_fu = '{default: FU_ALU};
        for (int unsigned w = 0; w < WIDTH; w++) begin
            is_fu[w] = fu_class_of(is_reg_q[w].packet);
        end
    end

    fu_arbiter #(
        .WIDTH(WIDTH)
    ) u_fu_arbiter (
        .is_valid (is_valid_q),
        .fu_class (is_fu),
        .mult_free(mult_free),
        .mem_ready(mem_ready),
        .grant    (grant)
    );

    // rs re-presents any ungranted entry, so IS reloads every cycle with no hold path.
    always_comb begin
        is_reg_d    = issue_packet;
        is_valid_d  = '0;
        confirm     = '0;
        ex_valid_d  = '0;
        ex_packet_d = '0;
        ex_fu_d     = ex_fu_q;
        mult_take   = 1'b0;
        for (int unsigned w = 0; w < WIDTH; w++) begin
            is_valid_d[w] = issue_packet[w].busy & issue_packet[w].send_issue & ~rollback_en;
            confirm[w]    = is_valid_q[w] & grant[w] & ~rollback_en;
            ex_valid_d[w] = confirm[w];
            ex_fu_d[w]    = is_fu[w];
            if (confirm[w]) begin
                ex_packet_d[w] = is_reg_q[w];
                if (is_fu[w] == FU_MULT) begin
                    mult_take = 1'b1;
                end
            end
        end
    end

    always_comb begin
        mult_cnt_d = mult_cnt_q;
        if (rollback_en) begin
            mult_cnt_d = '0;
        end else if (mult_take) begin
            mult_cnt_d = MULT_LOAD;
        end else if (mult_cnt_q != '0) begin
            mult_cnt_d = mult_cnt_q - CNT_ONE;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            is_reg_q    <= '0;
            is_valid_q  <= '0;
            ex_packet_q <= '0;
            ex_valid_q  <= '0;
            mult_cnt_q  <= '0;
            for (int unsigned w = 0; w < WIDTH; w++) begin
                ex_fu_q[w] <= FU_ALU;
            end
        end else begin
            is_reg_q    <= is_reg_d;
            is_valid_q  <= is_valid_d;
            ex_packet_q <= ex_packet_d;
            ex_valid_q  <= ex_valid_d;
            ex_fu_q     <= ex_fu_d;
            mult_cnt_q  <= mult_cnt_d;
        end
    end

    assign delete_confirm = confirm;
    assign ex_packet      = ex_packet_q;
    assign ex_valid       = ex_valid_q;
    assign ex_fu          = ex_fu_q;
    assign mult_busy      = (mult_cnt_q != '0);

endmodule
